// File: rtl/sseg_pkg.sv
// sseg_pkg
//   Shared definitions for the seven-segment scan driver: digit count,
//   idle output levels and the display buffer record used for both the
//   pending and the active (on-screen) frame.
package sseg_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam logic [7:0]  SSEG_BLANK = 8'hFF;  // all segments off (active low)
    localparam logic [7:0]  AN_OFF     = 8'hFF;  // no anode selected (active low)

    // One complete display frame: eight nibbles, per-digit enable, per-digit dp.
    typedef struct packed {
        logic [31:0] hex;
        logic [7:0]  en;
        logic [7:0]  dp;
    } disp_buf_t;

endpackage

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// hex_to_sseg
//   Combinational nibble-to-segment decoder for a common-anode display.
//   Ports:
//     nib  in  4  hex digit value
//     dp   in  1  1 = decimal point lit
//     seg  out 8  {dp,g,f,e,d,c,b,a}, active low
module hex_to_sseg (
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] raw;

    always_comb begin
        raw = 8'hFF;
        case (nib)
            4'h0: raw = 8'hC0;
            4'h1: raw = 8'hF9;
            4'h2: raw = 8'hA4;
            4'h3: raw = 8'hB0;
            4'h4: raw = 8'h99;
            4'h5: raw = 8'h92;
            4'h6: raw = 8'h82;
            4'h7: raw = 8'hF8;
            4'h8: raw = 8'h80;
            4'h9: raw = 8'h90;
            4'hA: raw = 8'h88;
            4'hB: raw = 8'h83;
            4'hC: raw = 8'hC6;
            4'hD: raw = 8'hA1;
            4'hE: raw = 8'h86;
            4'hF: raw = 8'h8E;
            default: raw = 8'hFF;
        endcase
    end

    // Bit 7 is the decimal point; lighting it pulls the line low.
    assign seg = {raw[7] & ~dp, raw[6:0]};

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
//   Time-multiplexed driver for an 8-digit common-anode seven-segment
//   display. Values are double-buffered: loads land in a pending buffer
//   and are committed to the on-screen buffer only at frame end.
//   Parameters:
//     N           prescaler width, each digit lit for 2^N clocks
//   Ports:
//     clk         in  1   system clock
//     rst         in  1   synchronous active-high reset
//     load        in  1   strobe capturing hex_in/dig_en/dp_in
//     hex_in      in  32  digit k = hex_in[4k+3:4k], digit 0 rightmost
//     dig_en      in  8   1 = digit k shown
//     dp_in       in  8   1 = decimal point of digit k lit
//     an          out 8   anode selects, active low
//     sseg        out 8   {dp,g,f,e,d,c,b,a}, active low
//     frame_done  out 1   one-cycle pulse after every frame end
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] hex_in,
    input  logic [7:0]  dig_en,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_done
);

    logic [N-1:0] tick_cnt;
    logic [2:0]   digit;
    disp_buf_t    act_buf;
    disp_buf_t    pend_buf;
    disp_buf_t    in_buf;
    logic         pend_valid;

    logic         tick_wrap;
    logic         frame_end;
    logic [3:0]   cur_nib;
    logic         cur_dp;
    logic         cur_en;
    logic [7:0]   cur_seg;

    assign in_buf    = {hex_in, dig_en, dp_in};
    assign tick_wrap = (tick_cnt == {N{1'b1}});
    assign frame_end = tick_wrap && (digit == 3'(NUM_DIGITS - 1));

    // Select the fields of the digit currently being scanned.
    assign cur_nib = act_buf.hex[{digit, 2'b00} +: 4];
    assign cur_dp  = act_buf.dp[digit];
    assign cur_en  = act_buf.en[digit];

    hex_to_sseg u_dec (
        .nib (cur_nib),
        .dp  (cur_dp),
        .seg (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            digit      <= '0;
            act_buf    <= '0;
            pend_buf   <= '0;
            pend_valid <= 1'b0;
            an         <= AN_OFF;
            sseg       <= SSEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            // Prescaler and digit counter both wrap naturally.
            tick_cnt <= tick_cnt + N'(1);
            if (tick_wrap)
                digit <= digit + 3'd1;

            frame_done <= frame_end;

            if (load)
                pend_buf <= in_buf;

            // Commit at frame end; a load in that same cycle bypasses pending.
            if (frame_end) begin
                if (load)
                    act_buf <= in_buf;
                else if (pend_valid)
                    act_buf <= pend_buf;
                pend_valid <= load;
            end else if (load) begin
                pend_valid <= 1'b1;
            end

            // Output stage: one registered update per digit change keeps an one-hot-low.
            an   <= cur_en ? ~(8'h01 << digit) : AN_OFF;
            sseg <= cur_en ? cur_seg : SSEG_BLANK;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver with N=3 (8 cycles per digit, 64-cycle frame).
module tb_sseg_scan_driver;

    typedef struct packed {
        logic [31:0] hex;
        logic [7:0]  en;
        logic [7:0]  dp;
    } m_t;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] hex_in;
    logic [7:0]  dig_en;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [7:0]  sseg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: the screen shows the most recent load issued at or
    // before the latest frame end; position in the frame is pure arithmetic.
    int  cyc = 0;
    m_t  active = '0;
    m_t  latest = '0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sseg_scan_driver #(.N(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .hex_in     (hex_in),
        .dig_en     (dig_en),
        .dp_in      (dp_in),
        .an         (an),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void exp_out(input m_t b, input int d,
                                     output logic [7:0] ean, output logic [7:0] eseg);
        logic [3:0] nib;
        nib = b.hex[d*4 +: 4];
        if (b.en[d]) begin
            ean  = ~(8'h01 << d);
            eseg = seg_tab[nib] & (b.dp[d] ? 8'h7F : 8'hFF);
        end else begin
            ean  = 8'hFF;
            eseg = 8'hFF;
        end
    endfunction

    // One clock: update the model at the edge, then compare #1 later.
    task automatic step();
        logic [7:0] ean, eseg;
        logic       efd;
        int         s;
        @(posedge clk);
        if (rst) begin
            cyc    = 0;
            active = '0;
            latest = '0;
            ean    = 8'hFF;
            eseg   = 8'hFF;
            efd    = 1'b0;
        end else begin
            s   = cyc % 64;
            efd = (s == 63);
            exp_out(active, (s / 8) % 8, ean, eseg);
            if (load) latest = {hex_in, dig_en, dp_in};
            if (s == 63) active = latest;
            cyc++;
        end
        #1;
        chk("an", an, ean);
        chk("sseg", sseg, eseg);
        chk("frame_done", {7'd0, frame_done}, {7'd0, efd});
    endtask

    // Advance until the next edge is frame position p.
    task automatic goto_pos(input int p);
        for (int i = 0; i < 64 && (cyc % 64) != p; i++) step();
    endtask

    task automatic do_load(input logic [31:0] h, input logic [7:0] e, input logic [7:0] p);
        hex_in = h; dig_en = e; dp_in = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; load = 1'b1; hex_in = 32'h8888_8888; dig_en = 8'hFF; dp_in = 8'hFF;

        // Reset, with a load held during reset that must be ignored.
        step(); step();
        chk("rst_an", an, 8'hFF);
        chk("rst_sseg", sseg, 8'hFF);
        chk("rst_fd", {7'd0, frame_done}, 8'd0);
        rst = 1'b0; load = 1'b0;
        repeat (30) step();
        chk("blank_first_frame_an", an, 8'hFF);

        // Basic scan.
        goto_pos(10);
        do_load(32'h7654_3210, 8'hFF, 8'h00);
        goto_pos(0);  step();
        chk("basic_d0_an", an, 8'hFE);  chk("basic_d0_sseg", sseg, 8'hC0);
        goto_pos(8);  step();
        chk("basic_d1_an", an, 8'hFD);  chk("basic_d1_sseg", sseg, 8'hF9);
        goto_pos(56); step();
        chk("basic_d7_an", an, 8'h7F);  chk("basic_d7_sseg", sseg, 8'hF8);

        // Blanking and decimal point.
        do_load(32'hFFFF_ABCD, 8'h0F, 8'h01);
        goto_pos(0);  step();
        chk("dp_d0_sseg", sseg, 8'h21);
        goto_pos(24); step();
        chk("dp_d3_sseg", sseg, 8'h88);  chk("dp_d3_an", an, 8'hF7);
        goto_pos(32); step();
        chk("blank_d4_an", an, 8'hFF);   chk("blank_d4_sseg", sseg, 8'hFF);

        // Double buffering: B is overwritten by C before the commit.
        do_load(32'h2222_2222, 8'hFF, 8'h00);
        goto_pos(0);  step();
        goto_pos(20); do_load(32'h3333_3333, 8'hFF, 8'h00);
        goto_pos(40); do_load(32'h4444_4444, 8'hFF, 8'h00);
        goto_pos(48); step();
        chk("dbuf_still_A", sseg, 8'hA4);
        goto_pos(0);  step();
        chk("dbuf_shows_C", sseg, 8'h99);

        // Frame-end collision: load on the frame-end cycle beats pending.
        goto_pos(10); do_load(32'h5555_5555, 8'hFF, 8'h00);
        goto_pos(63); do_load(32'h1111_1111, 8'hFF, 8'h00);
        chk("coll_fd", {7'd0, frame_done}, 8'd1);
        step();
        chk("coll_fd_once", {7'd0, frame_done}, 8'd0);
        chk("coll_sseg", sseg, 8'hF9);
        goto_pos(0);  step();
        chk("coll_next_frame", sseg, 8'hF9);

        // Randomized loads over several frames.
        for (int i = 0; i < 6 * 64; i++) begin
            if ($urandom_range(15) == 0) begin
                hex_in = $urandom; dig_en = 8'($urandom); dp_in = 8'($urandom); load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;

        // Mid-scan reset at digit 5.
        goto_pos(40);
        rst = 1'b1; step();
        chk("midrst_an", an, 8'hFF);  chk("midrst_sseg", sseg, 8'hFF);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (frame_done === 1'b1) break;
        end
        chk("midrst_fd_latency", 8'(n), 8'd64);
        chk("midrst_blank", an, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
